// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM states and the hex font.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [0:6] SEG_HEX_0 = 7'b0000001;
    localparam logic [0:6] SEG_HEX_1 = 7'b1001111;
    localparam logic [0:6] SEG_HEX_2 = 7'b0010010;
    localparam logic [0:6] SEG_HEX_3 = 7'b0000110;
    localparam logic [0:6] SEG_HEX_4 = 7'b1001100;
    localparam logic [0:6] SEG_HEX_5 = 7'b0100100;
    localparam logic [0:6] SEG_HEX_6 = 7'b0100000;
    localparam logic [0:6] SEG_HEX_7 = 7'b0001111;
    localparam logic [0:6] SEG_HEX_8 = 7'b0000000;
    localparam logic [0:6] SEG_HEX_9 = 7'b0000100;
    localparam logic [0:6] SEG_HEX_A = 7'b0001000;
    localparam logic [0:6] SEG_HEX_B = 7'b1100000;
    localparam logic [0:6] SEG_HEX_C = 7'b0110001;
    localparam logic [0:6] SEG_HEX_D = 7'b1000010;
    localparam logic [0:6] SEG_HEX_E = 7'b0110000;
    localparam logic [0:6] SEG_HEX_F = 7'b0111000;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_hex.sv
// 4-bit value to active-low 7-segment hex digit, shared by the up/down counter tops.
module seg7_hex
    import counter_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [0:6] o_seg
);

    // Font lookup
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_val)
            4'h0: o_seg = SEG_HEX_0;
            4'h1: o_seg = SEG_HEX_1;
            4'h2: o_seg = SEG_HEX_2;
            4'h3: o_seg = SEG_HEX_3;
            4'h4: o_seg = SEG_HEX_4;
            4'h5: o_seg = SEG_HEX_5;
            4'h6: o_seg = SEG_HEX_6;
            4'h7: o_seg = SEG_HEX_7;
            4'h8: o_seg = SEG_HEX_8;
            4'h9: o_seg = SEG_HEX_9;
            4'hA: o_seg = SEG_HEX_A;
            4'hB: o_seg = SEG_HEX_B;
            4'hC: o_seg = SEG_HEX_C;
            4'hD: o_seg = SEG_HEX_D;
            4'hE: o_seg = SEG_HEX_E;
            4'hF: o_seg = SEG_HEX_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_t_4_bits.sv
// Loadable 4-bit down-counter with prescaled tick, start/pause control,
// terminal-count pulse and hex display.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN (reload on terminal count
// and keep running instead of stopping in DONE).
module countdown_t_4_bits
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       start,
    input  logic       enable,
    output logic [3:0] count,
    output logic [0:6] hex,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_count, w_count_nxt;
    logic [3:0]    r_reload, w_reload_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (areset) begin
            r_state  <= IDLE;
            r_count  <= 4'd0;
            r_reload <= 4'd0;
            r_presc  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_presc  <= w_presc_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; load outranks start, start outranks tick
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_presc_nxt  = r_presc;
        w_done_nxt   = 1'b0;

        if (load) begin
            w_count_nxt  = load_val;
            w_reload_nxt = load_val;
            w_presc_nxt  = '0;
            w_state_nxt  = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (r_count != 4'd0) begin
                            w_state_nxt = RUN;
                            w_presc_nxt = '0;
                        end else begin
                            w_state_nxt = DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (r_presc == PRESC_LAST) begin
                            w_presc_nxt = '0;
                            if (r_count > 4'd1) begin
                                w_count_nxt = r_count - 4'd1;
                            end else begin
                                w_done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                                w_count_nxt = r_reload;
`else
                                w_count_nxt = 4'd0;
                                w_state_nxt = DONE;
`endif
                            end
                        end else begin
                            w_presc_nxt = r_presc + PW'(1);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        w_count_nxt = r_reload;
                        if (r_reload != 4'd0) begin
                            w_state_nxt = RUN;
                            w_presc_nxt = '0;
                        end else begin
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == RUN);
    end

    seg7_hex u_seg7_hex (
        .i_val (r_count),
        .o_seg (hex)
    );

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_countdown_t_4_bits.sv
// Bench for countdown_t_4_bits: two instances (PRESCALE 1 and 3) driven in
// lockstep, compared every cycle against a behavioural timer model.
module tb_countdown_t_4_bits;

    localparam int NI = 2;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       clk;
    logic       areset;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       enable;

    logic [3:0] count_o [NI];
    logic [0:6] hex_o   [NI];
    logic       busy_o  [NI];
    logic       done_o  [NI];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance
    int m_p   [NI] = '{1, 3};
    int m_st  [NI];
    int m_cnt [NI];
    int m_rld [NI];
    int m_en_cycles [NI];
    bit m_dn  [NI];

    logic [6:0] font [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    countdown_t_4_bits #(.PRESCALE(1)) u_dut_p1 (
        .clk(clk), .areset(areset), .load(load), .load_val(load_val),
        .start(start), .enable(enable), .count(count_o[0]), .hex(hex_o[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    countdown_t_4_bits #(.PRESCALE(3)) u_dut_p3 (
        .clk(clk), .areset(areset), .load(load), .load_val(load_val),
        .start(start), .enable(enable), .count(count_o[1]), .hex(hex_o[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Timer behaviour: counts enabled cycles while running; every PRESCALE of
    // them consumes one unit of the remaining count.
    task automatic model_edge(input int k, input logic a, input logic ld,
                              input logic [3:0] lv, input logic st, input logic en);
        m_dn[k] = 1'b0;
        if (a) begin
            m_st[k] = M_IDLE; m_cnt[k] = 0; m_rld[k] = 0; m_en_cycles[k] = 0;
        end else if (ld) begin
            m_st[k] = M_IDLE; m_cnt[k] = int'(lv); m_rld[k] = int'(lv); m_en_cycles[k] = 0;
        end else if (st && m_st[k] != M_RUN) begin
            if (m_st[k] == M_DONE) m_cnt[k] = m_rld[k];
            m_en_cycles[k] = 0;
            if (m_cnt[k] != 0) m_st[k] = M_RUN;
            else begin m_st[k] = M_DONE; m_dn[k] = 1'b1; end
        end else if (m_st[k] == M_RUN && en) begin
            m_en_cycles[k] = m_en_cycles[k] + 1;
            if (m_en_cycles[k] == m_p[k]) begin
                m_en_cycles[k] = 0;
                if (m_cnt[k] >= 2) m_cnt[k] = m_cnt[k] - 1;
                else begin
                    m_dn[k] = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    m_cnt[k] = m_rld[k];
`else
                    m_cnt[k] = 0;
                    m_st[k]  = M_DONE;
`endif
                end
            end
        end
    endtask

    task automatic step(input logic a, input logic ld, input logic [3:0] lv,
                        input logic st, input logic en);
        logic [6:0] h;
        areset = a; load = ld; load_val = lv; start = st; enable = en;
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_edge(k, a, ld, lv, st, en);
        #1;
        for (int k = 0; k < NI; k++) begin
            h = hex_o[k];
            check($sformatf("count[p%0d]", m_p[k]), 32'(count_o[k]), 32'(m_cnt[k]));
            check($sformatf("busy[p%0d]",  m_p[k]), 32'(busy_o[k]),  32'(m_st[k] == M_RUN));
            check($sformatf("done[p%0d]",  m_p[k]), 32'(done_o[k]),  32'(m_dn[k]));
            check($sformatf("hex[p%0d]",   m_p[k]), 32'(h),          32'(font[m_cnt[k]]));
        end
    endtask

    initial begin
        logic [6:0] h0;
        areset = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0; enable = 1'b0;

        // Reset and explicit reset values
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        h0 = hex_o[0];
        check("rst_count", 32'(count_o[0]), 32'd0);
        check("rst_busy",  32'(busy_o[0]),  32'd0);
        check("rst_done",  32'(done_o[0]),  32'd0);
        check("rst_hex",   32'(h0),         32'h01);

        // Load 5, start, full countdown
        step(0, 1, 4'd5, 0, 0);
        step(0, 0, 4'd0, 1, 1);
        for (int i = 0; i < 18; i++) step(0, 0, 4'd0, 0, 1);

        // Load 2, start, pause enable for 4 cycles mid-run
        step(0, 1, 4'd2, 0, 0);
        step(0, 0, 4'd0, 1, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 4'd0, 0, !(i >= 2 && i < 6));

        // Load 0, start -> immediate done
        step(0, 1, 4'd0, 0, 0);
        step(0, 0, 4'd0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 0, 1);
        step(0, 0, 4'd0, 1, 1);
        step(0, 0, 4'd0, 0, 1);

        // Load 7, run to count 3, then load 9 with start in the same cycle
        step(0, 1, 4'd7, 0, 0);
        step(0, 0, 4'd0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 0, 1);
        step(0, 1, 4'd9, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 0, 1);

        // Load 8, run to count 4, one-cycle reset mid-run
        step(0, 1, 4'd8, 0, 0);
        step(0, 0, 4'd0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 0, 1);
        step(1, 0, 4'd0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 0, 1);

        // Load 3, start, run long enough to see terminal behaviour repeat
        step(0, 1, 4'd3, 0, 0);
        step(0, 0, 4'd0, 1, 1);
        for (int i = 0; i < 24; i++) step(0, 0, 4'd0, 0, 1);
        step(0, 0, 4'd0, 1, 1);
        for (int i = 0; i < 12; i++) step(0, 0, 4'd0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 15) == 0,
                 4'($urandom),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
